// File: rtl/bus_bridge_if.sv
// -----------------------------------------------------------------------------
// bus_bridge_if
//   CPU data-bus bundle between the CPU memory stage and the bus responder.
//   Signals:
//     Bus_addr  [31:0]  byte address            (master -> slave)
//     Bus_wen           write enable, 1 = write  (master -> slave)
//     Bus_wdata [31:0]  write data               (master -> slave)
//     Bus_rdata [31:0]  combinational read data  (slave  -> master)
// -----------------------------------------------------------------------------
interface bus_bridge_if;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (
        output Bus_addr,
        output Bus_wen,
        output Bus_wdata,
        input  Bus_rdata
    );

    modport slave (
        input  Bus_addr,
        input  Bus_wen,
        input  Bus_wdata,
        output Bus_rdata
    );
endinterface

// File: rtl/bus_bridge.sv
// -----------------------------------------------------------------------------
// bus_bridge
//   Responder on the far side of the CPU data bus. Splits each access between
//   the data RAM and the peripheral page 0xFFFF_F000-0xFFFF_FFFF, and owns the
//   peripheral registers: 8-digit hex display (with scanning driver), free-
//   running timer, LED register, synchronized switches and buttons.
//
//   Ports:
//     cpu_clk     clock, all state on the rising edge
//     cpu_rst     asynchronous active-low reset
//     bus         CPU data bus (slave side), Bus_rdata is combinational
//     dram_addr   DRAM word address = Bus_addr[DRAM_AW+1:2]
//     dram_wen    DRAM write enable (never set for peripheral accesses)
//     dram_wdata  Bus_wdata passed through
//     dram_rdata  combinational DRAM read data
//     sw, button  asynchronous board inputs
//     led         LED register
//     dig_en      active-low one-hot digit enable
//     dn_seg      active-low segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bus_bridge #(
    parameter int SCAN_DIV = 50000,
    parameter int DRAM_AW  = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    bus_bridge_if.slave        bus,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dn_seg
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [11:0] OFF_DISP  = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    // Active-low 7-segment code with the decimal point off.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------ decode
    logic        periph;
    logic [11:0] off;
    logic        periph_wr;

    assign periph    = (bus.Bus_addr[31:12] == 20'hFFFFF);
    assign off       = bus.Bus_addr[11:0];
    assign periph_wr = bus.Bus_wen & periph;

    assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
    assign dram_wen   = bus.Bus_wen & ~periph;
    assign dram_wdata = bus.Bus_wdata;

    // ------------------------------------------------------------------ state
    logic [31:0]      disp_q,     disp_d;
    logic [31:0]      timer_q,    timer_d;
    logic [23:0]      led_q,      led_d;
    logic [23:0]      sw_meta_q,  sw_meta_d;
    logic [23:0]      sw_sync_q,  sw_sync_d;
    logic [4:0]       btn_meta_q, btn_meta_d;
    logic [4:0]       btn_sync_q, btn_sync_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [2:0]       idx_q,      idx_d;
    logic [7:0]       dig_en_q,   dig_en_d;
    logic [7:0]       dn_seg_q,   dn_seg_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        disp_d     = disp_q;
        timer_d    = timer_q + 32'd1;
        led_d      = led_q;
        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = button;
        btn_sync_d = btn_meta_q;
        div_d      = div_q + DIV_W'(1);
        idx_d      = idx_q;

        // A bus write takes priority over the timer increment on the same edge.
        if (periph_wr) begin
            case (off)
                OFF_DISP:  disp_d  = bus.Bus_wdata;
                OFF_TIMER: timer_d = bus.Bus_wdata;
                OFF_LED:   led_d   = bus.Bus_wdata[23:0];
                default:   ;
            endcase
        end

        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Outputs are registered from the current slot, so the first edge after
        // reset already drives digit 0 and a DISP write shows one cycle later.
        dig_en_d = ~(8'b1 << idx_q);
        dn_seg_d = seg_code(disp_q[{idx_q, 2'b00} +: 4]);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            disp_q     <= '0;
            timer_q    <= '0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFF;
            dn_seg_q   <= 8'hFF;
        end else begin
            disp_q     <= disp_d;
            timer_q    <= timer_d;
            led_q      <= led_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            dn_seg_q   <= dn_seg_d;
        end
    end

    assign led    = led_q;
    assign dig_en = dig_en_q;
    assign dn_seg = dn_seg_q;

    // --------------------------------------------------------------- read mux
    // Reads see register values before any same-cycle write lands.
    always_comb begin
        bus.Bus_rdata = dram_rdata;
        if (periph) begin
            case (off)
                OFF_DISP:  bus.Bus_rdata = disp_q;
                OFF_TIMER: bus.Bus_rdata = timer_q;
                OFF_LED:   bus.Bus_rdata = {8'h00, led_q};
                OFF_SW:    bus.Bus_rdata = {8'h00, sw_sync_q};
                OFF_BTN:   bus.Bus_rdata = {27'h0, btn_sync_q};
                default:   bus.Bus_rdata = 32'h0;
            endcase
        end
    end

endmodule
